// File: rtl/axis_id_router.sv
// AXI-Stream 1-to-N packet router. The first beat of each packet selects the
// destination from its t_id; the choice is locked until t_last. Packets whose
// id is out of range are consumed and discarded, and counted. A two-entry
// (main + skid) register slice keeps t_ready and t_valid registered while
// sustaining one beat per cycle.
module axis_id_router #(
  parameter int DATA_SIZE = 32,
  parameter int ID_SIZE   = 8,
  parameter int N_PORTS   = 4
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic                         s_t_valid,
  output logic                         s_t_ready,
  input  logic                         s_t_last,
  input  logic [DATA_SIZE-1:0]         s_t_data,
  input  logic [ID_SIZE-1:0]           s_t_id,
  output logic [N_PORTS-1:0]           m_t_valid,
  input  logic [N_PORTS-1:0]           m_t_ready,
  output logic [N_PORTS-1:0]           m_t_last,
  output logic [N_PORTS*DATA_SIZE-1:0] m_t_data,
  output logic [N_PORTS*ID_SIZE-1:0]   m_t_id,
  output logic [15:0]                  drop_count
);

  localparam int SEL_BITS = $clog2(N_PORTS);
  // One extra bit so the compare is correct even when N_PORTS == 2**ID_SIZE.
  localparam logic [ID_SIZE:0] LP_NPORTS = (ID_SIZE+1)'(N_PORTS);

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_BITS-1:0]   r_lock_dest;
  logic [SEL_BITS-1:0]   w_dest;
  logic                  w_store;
  logic                  w_drop_first;
  logic                  w_in_range;
  logic                  w_acc;

  logic                  r_s_ready;
  logic [15:0]           r_drop_cnt;

  // Main register: r_m_vld is the one-hot per-port valid for the held beat.
  logic [N_PORTS-1:0]    r_m_vld;
  logic [DATA_SIZE-1:0]  r_m_data;
  logic [ID_SIZE-1:0]    r_m_id;
  logic                  r_m_last;

  // Skid register: catches the beat accepted while main is stalled.
  logic                  r_sv;
  logic [DATA_SIZE-1:0]  r_s_data;
  logic [ID_SIZE-1:0]    r_s_id;
  logic                  r_s_last;
  logic [SEL_BITS-1:0]   r_s_dest;

  logic                  w_pop;
  logic                  w_main_free;
  logic                  w_sv_nxt;

  function automatic logic [N_PORTS-1:0] f_onehot(input logic [SEL_BITS-1:0] d);
    logic [N_PORTS-1:0] o;
    o = '0;
    for (int k = 0; k < N_PORTS; k++) o[k] = (SEL_BITS'(k) == d);
    return o;
  endfunction

  assign w_acc       = s_t_valid & r_s_ready;
  assign w_in_range  = ({1'b0, s_t_id} < LP_NPORTS);
  assign w_pop       = |(r_m_vld & m_t_ready);
  assign w_main_free = (r_m_vld == '0) | w_pop;
  // Skid drains whenever main frees up; it fills only when main cannot take the beat.
  assign w_sv_nxt    = r_sv ? ~w_main_free : (w_store & ~w_main_free);

  // Routing FSM: decides per accepted beat whether it is kept and where it goes.
  always_comb begin
    w_state_nxt  = r_state;
    w_store      = 1'b0;
    w_dest       = r_lock_dest;
    w_drop_first = 1'b0;
    if (w_acc) begin
      case (r_state)
        ST_IDLE: begin
          if (w_in_range) begin
            w_store = 1'b1;
            w_dest  = s_t_id[SEL_BITS-1:0];
            if (!s_t_last) w_state_nxt = ST_FWD;
          end else begin
            w_drop_first = 1'b1;
            if (!s_t_last) w_state_nxt = ST_DROP;
          end
        end
        ST_FWD: begin
          w_store = 1'b1;
          if (s_t_last) w_state_nxt = ST_IDLE;
        end
        ST_DROP: begin
          if (s_t_last) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state, routing lock and drop counter.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= ST_IDLE;
      r_lock_dest <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_store) r_lock_dest <= w_dest;
      if (w_drop_first && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Main/skid register slice; s_t_ready is registered as "skid will be empty".
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_s_ready <= 1'b0;
      r_m_vld   <= '0;
      r_m_data  <= '0;
      r_m_id    <= '0;
      r_m_last  <= 1'b0;
      r_sv      <= 1'b0;
      r_s_data  <= '0;
      r_s_id    <= '0;
      r_s_last  <= 1'b0;
      r_s_dest  <= '0;
    end else begin
      r_s_ready <= ~w_sv_nxt;
      r_sv      <= w_sv_nxt;
      if (w_main_free) begin
        if (r_sv) begin
          r_m_vld  <= f_onehot(r_s_dest);
          r_m_data <= r_s_data;
          r_m_id   <= r_s_id;
          r_m_last <= r_s_last;
        end else if (w_store) begin
          r_m_vld  <= f_onehot(w_dest);
          r_m_data <= s_t_data;
          r_m_id   <= s_t_id;
          r_m_last <= s_t_last;
        end else begin
          r_m_vld  <= '0;
        end
      end
      if (!r_sv && w_store && !w_main_free) begin
        r_s_data <= s_t_data;
        r_s_id   <= s_t_id;
        r_s_last <= s_t_last;
        r_s_dest <= w_dest;
      end
    end
  end

  assign s_t_ready  = r_s_ready;
  assign m_t_valid  = r_m_vld;
  assign m_t_last   = {N_PORTS{r_m_last}};
  assign m_t_data   = {N_PORTS{r_m_data}};
  assign m_t_id     = {N_PORTS{r_m_id}};
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_axis_id_router.sv
// Directed bench for axis_id_router: a per-cycle vector table for routing,
// locking and dropping, plus stream sequences for back-pressure, back-to-back
// packets and mid-packet reset.
module tb_axis_id_router;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          s_t_valid = 1'b0;
  logic          s_t_ready;
  logic          s_t_last = 1'b0;
  logic [31:0]   s_t_data = '0;
  logic [7:0]    s_t_id = '0;
  logic [3:0]    m_t_valid;
  logic [3:0]    m_t_ready = 4'hF;
  logic [3:0]    m_t_last;
  logic [127:0]  m_t_data;
  logic [31:0]   m_t_id;
  logic [15:0]   drop_count;

  int n_chk = 0;
  int n_err = 0;

  axis_id_router #(.DATA_SIZE(32), .ID_SIZE(8), .N_PORTS(4)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_t_valid(s_t_valid), .s_t_ready(s_t_ready), .s_t_last(s_t_last),
    .s_t_data(s_t_data), .s_t_id(s_t_id),
    .m_t_valid(m_t_valid), .m_t_ready(m_t_ready), .m_t_last(m_t_last),
    .m_t_data(m_t_data), .m_t_id(m_t_id), .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic        l;
    logic [31:0] d;
    logic [7:0]  id;
    logic        srdy;
    logic [3:0]  mv;
    logic        ml;
    logic [31:0] md;
    logic [7:0]  mid;
    logic [15:0] dc;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic l, input logic [31:0] d,
                              input logic [7:0] id, input logic [3:0] mv,
                              input logic ml, input logic [31:0] md,
                              input logic [7:0] mid, input logic [15:0] dc);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.id = id; r.srdy = 1'b1;
    r.mv = mv; r.ml = ml; r.md = md; r.mid = mid; r.dc = dc;
    return r;
  endfunction

  typedef struct packed {logic [31:0] d; logic [7:0] id; logic last;} beat_t;
  beat_t       src_q[$];
  int          rcv_port[$];
  logic [31:0] rcv_data[$];
  logic        rcv_last[$];
  int          rcv_cyc[$];
  int          acc_cyc[$];
  logic        srdy_log[$];

  task automatic clear_logs();
    rcv_port.delete(); rcv_data.delete(); rcv_last.delete();
    rcv_cyc.delete(); acc_cyc.delete(); srdy_log.delete();
  endtask

  // Drives src_q into the DUT and logs every handshake; port stall_port has
  // its ready held low for stall_len cycles starting at cycle stall_from.
  task automatic run_stream(input int stall_port, input int stall_from,
                            input int stall_len, input int max_cyc);
    int          cyc;
    logic        pstall;
    logic [3:0]  pv;
    logic [127:0] pd;
    cyc = 0;
    pstall = 1'b0;
    pv = '0;
    pd = '0;
    while ((src_q.size() > 0 || m_t_valid != 4'b0) && cyc < max_cyc) begin
      if (src_q.size() > 0) begin
        s_t_valid = 1'b1;
        s_t_data  = src_q[0].d;
        s_t_id    = src_q[0].id;
        s_t_last  = src_q[0].last;
      end else begin
        s_t_valid = 1'b0;
        s_t_data  = '0;
        s_t_id    = '0;
        s_t_last  = 1'b0;
      end
      m_t_ready = 4'hF;
      if (cyc >= stall_from && cyc < stall_from + stall_len) m_t_ready[stall_port] = 1'b0;
      chk($sformatf("onehot0 c%0d", cyc), 128'($onehot0(m_t_valid)), 128'(1));
      if (pstall) begin
        chk($sformatf("stall vld c%0d", cyc), 128'(m_t_valid), 128'(pv));
        chk($sformatf("stall data c%0d", cyc), m_t_data, pd);
      end
      srdy_log.push_back(s_t_ready);
      if (s_t_valid && s_t_ready) begin
        void'(src_q.pop_front());
        acc_cyc.push_back(cyc);
      end
      for (int k = 0; k < 4; k++) begin
        if (m_t_valid[k] && m_t_ready[k]) begin
          rcv_port.push_back(k);
          rcv_data.push_back(m_t_data[k*32 +: 32]);
          rcv_last.push_back(m_t_last[k]);
          rcv_cyc.push_back(cyc);
        end
      end
      pstall = |(m_t_valid & ~m_t_ready);
      pv = m_t_valid;
      pd = m_t_data;
      @(posedge aclk); #1;
      cyc++;
    end
    chk("stream timeout", 128'(cyc < max_cyc), 128'(1));
    s_t_valid = 1'b0;
    s_t_last  = 1'b0;
    m_t_ready = 4'hF;
  endtask

  vec_t tbl[19];

  initial begin
    // Routing / lock / drop table; expected outputs are those seen before the edge.
    tbl[0]  = mk(0, 0, 32'h00, 8'd0, 4'b0000, 0, 32'h00, 8'd0, 16'd0);
    tbl[1]  = mk(1, 0, 32'hA0, 8'd2, 4'b0000, 0, 32'h00, 8'd0, 16'd0);
    tbl[2]  = mk(1, 0, 32'hA1, 8'd2, 4'b0100, 0, 32'hA0, 8'd2, 16'd0);
    tbl[3]  = mk(1, 1, 32'hA2, 8'd2, 4'b0100, 0, 32'hA1, 8'd2, 16'd0);
    tbl[4]  = mk(0, 0, 32'h00, 8'd0, 4'b0100, 1, 32'hA2, 8'd2, 16'd0);
    tbl[5]  = mk(1, 0, 32'hB0, 8'd2, 4'b0000, 0, 32'h00, 8'd0, 16'd0);
    tbl[6]  = mk(1, 0, 32'hB1, 8'd1, 4'b0100, 0, 32'hB0, 8'd2, 16'd0);
    tbl[7]  = mk(1, 1, 32'hB2, 8'd1, 4'b0100, 0, 32'hB1, 8'd1, 16'd0);
    tbl[8]  = mk(0, 0, 32'h00, 8'd0, 4'b0100, 1, 32'hB2, 8'd1, 16'd0);
    tbl[9]  = mk(1, 0, 32'hC0, 8'd9, 4'b0000, 0, 32'h00, 8'd0, 16'd0);
    tbl[10] = mk(1, 0, 32'hC1, 8'd0, 4'b0000, 0, 32'h00, 8'd0, 16'd1);
    tbl[11] = mk(1, 0, 32'hC2, 8'd9, 4'b0000, 0, 32'h00, 8'd0, 16'd1);
    tbl[12] = mk(1, 1, 32'hC3, 8'd9, 4'b0000, 0, 32'h00, 8'd0, 16'd1);
    tbl[13] = mk(1, 1, 32'h55, 8'd0, 4'b0000, 0, 32'h00, 8'd0, 16'd1);
    tbl[14] = mk(0, 0, 32'h00, 8'd0, 4'b0001, 1, 32'h55, 8'd0, 16'd1);
    tbl[15] = mk(1, 1, 32'hD0, 8'd4, 4'b0000, 0, 32'h00, 8'd0, 16'd1);
    tbl[16] = mk(1, 1, 32'hE0, 8'd3, 4'b0000, 0, 32'h00, 8'd0, 16'd2);
    tbl[17] = mk(0, 0, 32'h00, 8'd0, 4'b1000, 1, 32'hE0, 8'd3, 16'd2);
    tbl[18] = mk(0, 0, 32'h00, 8'd0, 4'b0000, 0, 32'h00, 8'd0, 16'd2);

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst s_ready", 128'(s_t_ready), 128'(0));
    chk("rst m_valid", 128'(m_t_valid), 128'(0));
    chk("rst m_last", 128'(m_t_last), 128'(0));
    chk("rst m_data", m_t_data, 128'(0));
    chk("rst m_id", 128'(m_t_id), 128'(0));
    chk("rst drop", 128'(drop_count), 128'(0));
    #3 areset_n = 1'b1;
    @(posedge aclk); #1;

    for (int i = 0; i < 19; i++) begin
      s_t_valid = tbl[i].v;
      s_t_last  = tbl[i].l;
      s_t_data  = tbl[i].d;
      s_t_id    = tbl[i].id;
      m_t_ready = 4'hF;
      chk($sformatf("row%0d s_ready", i), 128'(s_t_ready), 128'(tbl[i].srdy));
      chk($sformatf("row%0d m_valid", i), 128'(m_t_valid), 128'(tbl[i].mv));
      chk($sformatf("row%0d drop", i), 128'(drop_count), 128'(tbl[i].dc));
      if (tbl[i].mv != 4'b0) begin
        chk($sformatf("row%0d m_data", i), m_t_data, {4{tbl[i].md}});
        chk($sformatf("row%0d m_last", i), 128'(m_t_last), 128'({4{tbl[i].ml}}));
        chk($sformatf("row%0d m_id", i), 128'(m_t_id), 128'({4{tbl[i].mid}}));
      end
      @(posedge aclk); #1;
    end
    s_t_valid = 1'b0;
    s_t_last  = 1'b0;

    // Back-pressure: port 1 stalled for the first 5 cycles of a 6-beat packet.
    clear_logs();
    for (int i = 0; i < 6; i++) src_q.push_back({32'hF0 + 32'(i), 8'd1, (i == 5)});
    run_stream(1, 0, 5, 40);
    chk("bp s_ready c1", 128'(srdy_log[1]), 128'(1));
    chk("bp s_ready c2", 128'(srdy_log[2]), 128'(0));
    chk("bp s_ready c4", 128'(srdy_log[4]), 128'(0));
    chk("bp count", 128'(rcv_data.size()), 128'(6));
    if (rcv_data.size() == 6) begin
      chk("bp first cyc", 128'(rcv_cyc[0]), 128'(5));
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("bp data%0d", i), 128'(rcv_data[i]), 128'(32'hF0 + 32'(i)));
        chk($sformatf("bp port%0d", i), 128'(rcv_port[i]), 128'(1));
        chk($sformatf("bp last%0d", i), 128'(rcv_last[i]), 128'(i == 5));
      end
    end

    // Back-to-back: id 0 (4 beats) then id 3 (3 beats), all ready.
    clear_logs();
    for (int i = 0; i < 4; i++) src_q.push_back({32'h10 + 32'(i), 8'd0, (i == 3)});
    for (int i = 0; i < 3; i++) src_q.push_back({32'h30 + 32'(i), 8'd3, (i == 2)});
    run_stream(0, 0, 0, 40);
    chk("b2b count", 128'(rcv_data.size()), 128'(7));
    chk("b2b acc count", 128'(acc_cyc.size()), 128'(7));
    if (rcv_data.size() == 7 && acc_cyc.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("b2b acc cyc%0d", i), 128'(acc_cyc[i]), 128'(i));
        chk($sformatf("b2b out cyc%0d", i), 128'(rcv_cyc[i]), 128'(i + 1));
        chk($sformatf("b2b port%0d", i), 128'(rcv_port[i]), 128'((i < 4) ? 0 : 3));
        chk($sformatf("b2b data%0d", i), 128'(rcv_data[i]),
            128'((i < 4) ? 32'h10 + 32'(i) : 32'h30 + 32'(i - 4)));
        chk($sformatf("b2b last%0d", i), 128'(rcv_last[i]), 128'(i == 3 || i == 6));
      end
    end

    // Mid-packet reset with both buffer entries full.
    m_t_ready = 4'h0;
    s_t_valid = 1'b1; s_t_id = 8'd2; s_t_data = 32'h60; s_t_last = 1'b0;
    chk("mr s_ready0", 128'(s_t_ready), 128'(1));
    @(posedge aclk); #1;
    s_t_data = 32'h61;
    chk("mr s_ready1", 128'(s_t_ready), 128'(1));
    @(posedge aclk); #1;
    s_t_valid = 1'b0;
    chk("mr full s_ready", 128'(s_t_ready), 128'(0));
    chk("mr full m_valid", 128'(m_t_valid), 128'(4'b0100));
    chk("mr drop before", 128'(drop_count), 128'(2));
    #2 areset_n = 1'b0;
    #1;
    chk("mr async m_valid", 128'(m_t_valid), 128'(0));
    chk("mr async s_ready", 128'(s_t_ready), 128'(0));
    chk("mr async drop", 128'(drop_count), 128'(0));
    chk("mr async data", m_t_data, 128'(0));
    @(posedge aclk); #2;
    chk("mr held s_ready", 128'(s_t_ready), 128'(0));
    areset_n = 1'b1;
    m_t_ready = 4'hF;
    @(posedge aclk); #1;
    chk("mr release s_ready", 128'(s_t_ready), 128'(1));
    chk("mr release m_valid", 128'(m_t_valid), 128'(0));
    clear_logs();
    src_q.push_back({32'h77, 8'd1, 1'b1});
    run_stream(0, 0, 0, 20);
    chk("mr count", 128'(rcv_data.size()), 128'(1));
    if (rcv_data.size() == 1) begin
      chk("mr port", 128'(rcv_port[0]), 128'(1));
      chk("mr data", 128'(rcv_data[0]), 128'(32'h77));
      chk("mr last", 128'(rcv_last[0]), 128'(1));
      chk("mr out cyc", 128'(rcv_cyc[0]), 128'(1));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
